// File: rtl/debug_terminal.sv
// Streams a fixed-format ASCII status line (flags + hex channel values) to the AVR
// transmitter and decodes single-letter commands. Define DEBUG_TERMINAL_CHECKSUM_EN to append "*HH".
module debug_terminal #(
  parameter int NUM_CH   = 4,
  parameter int CH_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_tmr,
  input  logic [NUM_CH*CH_WIDTH-1:0] i_ch_data,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_new_rx_data,
  input  logic                       i_tx_busy,
  output logic [7:0]                 o_tx_data,
  output logic                       o_new_tx_data,
  output logic                       o_motor_armed,
  output logic                       o_data_record,
  output logic                       o_soft_rst,
  output logic                       o_paused,
  output logic [7:0]                 o_overrun_cnt,
  output logic                       o_msg_busy
);

  localparam int HD       = (CH_WIDTH + 3) / 4;
  localparam int BODY_END = 3 + NUM_CH * (1 + HD);
`ifdef DEBUG_TERMINAL_CHECKSUM_EN
  localparam int MSG_LEN  = BODY_END + 5;
`else
  localparam int MSG_LEN  = BODY_END + 2;
`endif
  localparam logic [6:0] BODY_END_I = 7'(BODY_END);
  localparam logic [6:0] CR_IDX_I   = 7'(MSG_LEN - 2);
  localparam logic [6:0] LAST_IDX_I = 7'(MSG_LEN - 1);
  localparam logic [3:0] HD_I       = 4'(HD);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  state_t                     r_state;
  logic [6:0]                 r_idx;
  logic [3:0]                 r_ch;
  logic [3:0]                 r_dig;
  logic [NUM_CH*CH_WIDTH-1:0] r_snap;
  logic                       r_snap_armed;
  logic                       r_snap_rec;
  logic                       r_snap_ovf;
  logic                       r_ovf;
`ifdef DEBUG_TERMINAL_CHECKSUM_EN
  logic [7:0]                 r_csum;
`endif

  logic [4*HD-1:0] w_chval;
  logic [3:0]      w_nib;
  logic [7:0]      w_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // r_dig counts 0 for the leading space, then 1..HD for digits MSB first.
  always_comb begin
    w_chval = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (r_ch == 4'(k)) w_chval[CH_WIDTH-1:0] = r_snap[k*CH_WIDTH +: CH_WIDTH];
    w_nib = '0;
    for (int j = 0; j < HD; j++)
      if (r_dig == 4'(HD - j)) w_nib = w_chval[4*j +: 4];
  end

  always_comb begin
    w_byte = 8'h0A;
    if (r_idx == 7'd0)              w_byte = r_snap_armed ? "A" : "D";
    else if (r_idx == 7'd1)         w_byte = r_snap_rec ? "R" : "I";
    else if (r_idx == 7'd2)         w_byte = r_snap_ovf ? "O" : "-";
    else if (r_idx < BODY_END_I)    w_byte = (r_dig == 4'd0) ? " " : hex_ascii(w_nib);
`ifdef DEBUG_TERMINAL_CHECKSUM_EN
    else if (r_idx == BODY_END_I)         w_byte = "*";
    else if (r_idx == BODY_END_I + 7'd1)  w_byte = hex_ascii(r_csum[7:4]);
    else if (r_idx == BODY_END_I + 7'd2)  w_byte = hex_ascii(r_csum[3:0]);
`endif
    else if (r_idx == CR_IDX_I)     w_byte = 8'h0D;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_ch          <= '0;
      r_dig         <= '0;
      r_snap        <= '0;
      r_snap_armed  <= 1'b0;
      r_snap_rec    <= 1'b0;
      r_snap_ovf    <= 1'b0;
      r_ovf         <= 1'b0;
`ifdef DEBUG_TERMINAL_CHECKSUM_EN
      r_csum        <= '0;
`endif
      o_tx_data     <= 8'h00;
      o_new_tx_data <= 1'b0;
      o_motor_armed <= 1'b0;
      o_data_record <= 1'b0;
      o_soft_rst    <= 1'b0;
      o_paused      <= 1'b0;
      o_overrun_cnt <= 8'h00;
      o_msg_busy    <= 1'b0;
    end else begin
      o_new_tx_data <= 1'b0;
      o_soft_rst    <= 1'b0;
      if (i_new_rx_data) begin
        case (i_rx_data)
          "m":     o_motor_armed <= ~o_motor_armed;
          "d":     o_data_record <= ~o_data_record;
          "p":     o_paused      <= ~o_paused;
          "r":     o_soft_rst    <= 1'b1;
          default: ;
        endcase
      end
      case (r_state)
        IDLE: if (i_tmr && !o_paused) begin
          r_state    <= LOAD;
          o_msg_busy <= 1'b1;
        end
        LOAD: begin
          r_snap       <= i_ch_data;
          r_snap_armed <= o_motor_armed;
          r_snap_rec   <= o_data_record;
          r_snap_ovf   <= r_ovf;
          r_ovf        <= 1'b0;
          r_idx        <= '0;
          r_ch         <= '0;
          r_dig        <= '0;
`ifdef DEBUG_TERMINAL_CHECKSUM_EN
          r_csum       <= '0;
`endif
          r_state      <= SEND;
        end
        SEND: if (!i_tx_busy) begin
          o_tx_data     <= w_byte;
          o_new_tx_data <= 1'b1;
`ifdef DEBUG_TERMINAL_CHECKSUM_EN
          if (r_idx < BODY_END_I) r_csum <= r_csum ^ w_byte;
`endif
          r_state       <= WAIT;
        end
        WAIT: begin
          if (r_idx == LAST_IDX_I) begin
            r_state    <= IDLE;
            o_msg_busy <= 1'b0;
          end else begin
            r_idx   <= r_idx + 7'd1;
            r_state <= SEND;
            if (r_idx >= 7'd3 && r_idx < BODY_END_I) begin
              if (r_dig == HD_I) begin
                r_dig <= '0;
                r_ch  <= r_ch + 4'd1;
              end else begin
                r_dig <= r_dig + 4'd1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // Placed after the FSM so a request arriving during LOAD survives the flag clear.
      if (i_tmr && r_state != IDLE) begin
        r_ovf <= 1'b1;
        if (o_overrun_cnt != 8'hFF) o_overrun_cnt <= o_overrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_debug_terminal.sv
// Randomized self-checking bench for debug_terminal (2 channels x 8 bits) against a
// message-level reference model; honours DEBUG_TERMINAL_CHECKSUM_EN when defined.
module tb_debug_terminal;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int DW  = NCH * CW;
  localparam int HD  = (CW + 3) / 4;
`ifdef DEBUG_TERMINAL_CHECKSUM_EN
  localparam int L = 5 + NCH * (1 + HD) + 3;
`else
  localparam int L = 5 + NCH * (1 + HD);
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_tmr;
  logic [DW-1:0] i_ch_data;
  logic [7:0]    i_rx_data;
  logic          i_new_rx_data;
  logic          i_tx_busy;
  logic [7:0]    o_tx_data;
  logic          o_new_tx_data;
  logic          o_motor_armed;
  logic          o_data_record;
  logic          o_soft_rst;
  logic          o_paused;
  logic [7:0]    o_overrun_cnt;
  logic          o_msg_busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  byte unsigned capq[$];
  int           capc[$];
  byte unsigned expq[$];

  bit m_armed, m_rec, m_paused, m_ovf;
  int m_cnt;

  always #5 clk = ~clk;

  debug_terminal #(.NUM_CH(NCH), .CH_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_tmr(i_tmr), .i_ch_data(i_ch_data),
    .i_rx_data(i_rx_data), .i_new_rx_data(i_new_rx_data), .i_tx_busy(i_tx_busy),
    .o_tx_data(o_tx_data), .o_new_tx_data(o_new_tx_data),
    .o_motor_armed(o_motor_armed), .o_data_record(o_data_record),
    .o_soft_rst(o_soft_rst), .o_paused(o_paused),
    .o_overrun_cnt(o_overrun_cnt), .o_msg_busy(o_msg_busy)
  );

  // Byte capture just after each rising edge, tagged with the cycle number.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (o_new_tx_data === 1'b1) begin
      capq.push_back(o_tx_data);
      capc.push_back(cyc);
    end
  end

  function automatic byte unsigned hexc(int n);
    return (n < 10) ? byte'(48 + n) : byte'(55 + n);
  endfunction

  function void model_reset();
    m_armed = 0; m_rec = 0; m_paused = 0; m_ovf = 0; m_cnt = 0;
  endfunction

  // Builds the full expected line from the values captured at message start.
  function void build_exp(logic [DW-1:0] ch);
    int unsigned v;
    byte unsigned x;
    expq.delete();
    expq.push_back(m_armed ? "A" : "D");
    expq.push_back(m_rec ? "R" : "I");
    expq.push_back(m_ovf ? "O" : "-");
    for (int k = 0; k < NCH; k++) begin
      v = int'(ch[k*CW +: CW]);
      expq.push_back(" ");
      for (int j = HD - 1; j >= 0; j--) expq.push_back(hexc(int'((v >> (4*j)) & 15)));
    end
`ifdef DEBUG_TERMINAL_CHECKSUM_EN
    x = 8'h00;
    foreach (expq[i]) x = x ^ expq[i];
    expq.push_back("*");
    expq.push_back(hexc(int'(x >> 4)));
    expq.push_back(hexc(int'(x & 8'h0F)));
`endif
    expq.push_back(8'h0D);
    expq.push_back(8'h0A);
    m_ovf = 0;
  endfunction

  function void model_overrun();
    m_ovf = 1;
    if (m_cnt < 255) m_cnt++;
  endfunction

  task pulse_tmr();
    i_tmr = 1'b1;
    @(negedge clk);
    i_tmr = 1'b0;
  endtask

  task send_rx(input byte unsigned b);
    i_rx_data = b;
    i_new_rx_data = 1'b1;
    @(negedge clk);
    i_new_rx_data = 1'b0;
    case (b)
      "m": m_armed  = !m_armed;
      "d": m_rec    = !m_rec;
      "p": m_paused = !m_paused;
      default: ;
    endcase
  endtask

  task start_msg(input logic [DW-1:0] ch);
    i_ch_data = ch;
    capq.delete();
    capc.delete();
    build_exp(ch);
    pulse_tmr();
    @(negedge clk);
  endtask

  task wait_bytes(input int n, input bit rnd, output bit ok);
    int budget = 0;
    ok = 1'b1;
    while (capq.size() < n) begin
      if (budget++ > 3000) begin ok = 1'b0; break; end
      if (rnd) i_tx_busy = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    if (rnd) i_tx_busy = 1'b0;
  endtask

  task finish_idle();
    repeat (2) @(negedge clk);
  endtask

  task test_reset();
    rst = 1'b1; i_tmr = 0; i_ch_data = '0; i_rx_data = 0; i_new_rx_data = 0; i_tx_busy = 0;
    repeat (3) @(negedge clk);
    checks++; if (o_tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h want 00", o_tx_data); end
    checks++; if (o_new_tx_data !== 1'b0) begin errors++; $display("[TB] FAIL reset_new_tx: got %b want 0", o_new_tx_data); end
    checks++; if ({o_motor_armed, o_data_record, o_paused, o_soft_rst} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b want 0000", {o_motor_armed, o_data_record, o_paused, o_soft_rst}); end
    checks++; if (o_overrun_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_ovr_cnt: got %0d want 0", o_overrun_cnt); end
    checks++; if (o_msg_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_msg_busy: got %b want 0", o_msg_busy); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task test_basic();
    bit ok;
    int bad = 0;
    start_msg(16'hF03A);
    wait_bytes(L, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout: got %0d bytes want %0d", capq.size(), L); end
    for (int i = 0; i < L; i++) begin
      checks++;
      if (i >= capq.size() || capq[i] !== expq[i]) begin
        errors++; $display("[TB] FAIL basic_byte%0d: got %h want %h", i, (i < capq.size()) ? capq[i] : 8'h00, expq[i]); end
    end
    for (int i = 1; i < capc.size(); i++) if (capc[i] - capc[i-1] != 2) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL basic_spacing: got %0d irregular gaps want 0", bad); end
    finish_idle();
    checks++; if (capq.size() != L || o_msg_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_end: got %0d bytes busy=%b want %0d busy=0", capq.size(), o_msg_busy, L); end
  endtask

  task test_commands();
    bit ok;
    byte unsigned cmds[6] = '{"m", "M", "d", "x", "D", "p"};
    foreach (cmds[i]) begin
      send_rx(cmds[i]);
      checks++;
      if ({o_motor_armed, o_data_record, o_paused} !== {m_armed, m_rec, m_paused}) begin
        errors++; $display("[TB] FAIL cmd_%c: got %b want %b", cmds[i],
          {o_motor_armed, o_data_record, o_paused}, {m_armed, m_rec, m_paused}); end
    end
    capq.delete();
    pulse_tmr();
    repeat (20) @(negedge clk);
    checks++; if (capq.size() != 0 || o_msg_busy !== 1'b0 || o_overrun_cnt !== 8'(m_cnt)) begin
      errors++; $display("[TB] FAIL paused_tmr: got bytes=%0d busy=%b cnt=%0d want 0 0 %0d",
        capq.size(), o_msg_busy, o_overrun_cnt, m_cnt); end
    send_rx("p");
    start_msg(DW'($urandom()));
    wait_bytes(L, 1'b0, ok);
    for (int i = 0; i < L; i++) begin
      checks++;
      if (i >= capq.size() || capq[i] !== expq[i]) begin
        errors++; $display("[TB] FAIL resume_byte%0d: got %h want %h", i, (i < capq.size()) ? capq[i] : 8'h00, expq[i]); end
    end
    finish_idle();
    send_rx("r");
    checks++; if (o_soft_rst !== 1'b1) begin errors++; $display("[TB] FAIL soft_rst_high: got %b want 1", o_soft_rst); end
    @(negedge clk);
    checks++; if (o_soft_rst !== 1'b0 || o_motor_armed !== m_armed) begin
      errors++; $display("[TB] FAIL soft_rst_after: got rst=%b armed=%b want 0 %b", o_soft_rst, o_motor_armed, m_armed); end
  endtask

  task test_random();
    bit ok;
    byte unsigned pick[4] = '{"m", "d", "p", "Z"};
    for (int n = 0; n < 6; n++) begin
      start_msg(DW'($urandom()));
      i_ch_data = DW'($urandom());
      wait_bytes($urandom_range(1, L - 2), 1'b1, ok);
      send_rx(pick[$urandom_range(0, 3)]);
      wait_bytes(L, 1'b1, ok);
      for (int i = 0; i < L; i++) begin
        checks++;
        if (i >= capq.size() || capq[i] !== expq[i]) begin
          errors++; $display("[TB] FAIL rand%0d_byte%0d: got %h want %h", n, i, (i < capq.size()) ? capq[i] : 8'h00, expq[i]); end
      end
      finish_idle();
      checks++; if ({o_motor_armed, o_data_record, o_paused} !== {m_armed, m_rec, m_paused}) begin
        errors++; $display("[TB] FAIL rand%0d_flags: got %b want %b", n,
          {o_motor_armed, o_data_record, o_paused}, {m_armed, m_rec, m_paused}); end
      if (m_paused) send_rx("p");
    end
  endtask

  task test_back_to_back_busy();
    bit ok;
    int bad = 0;
    start_msg(DW'($urandom()));
    wait_bytes(3, 1'b0, ok);
    i_tx_busy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (o_new_tx_data !== 1'b0 || capq.size() != 3) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL busy_hold: got %0d bad cycles want 0", bad); end
    i_tx_busy = 1'b0;
    wait_bytes(L, 1'b0, ok);
    finish_idle();
    checks++; if (capq.size() != L) begin errors++; $display("[TB] FAIL busy_count: got %0d want %0d", capq.size(), L); end
    for (int i = 0; i < L; i++) begin
      checks++;
      if (i >= capq.size() || capq[i] !== expq[i]) begin
        errors++; $display("[TB] FAIL busy_byte%0d: got %h want %h", i, (i < capq.size()) ? capq[i] : 8'h00, expq[i]); end
    end
  endtask

  task test_overrun();
    bit ok;
    for (int n = 0; n < 3; n++) begin
      start_msg(DW'($urandom()));
      if (n == 0) begin
        wait_bytes(2, 1'b0, ok);
        repeat (3) begin pulse_tmr(); model_overrun(); @(negedge clk); end
        checks++; if (o_overrun_cnt !== 8'(m_cnt)) begin
          errors++; $display("[TB] FAIL ovr_cnt: got %0d want %0d", o_overrun_cnt, m_cnt); end
      end
      wait_bytes(L, 1'b0, ok);
      for (int i = 0; i < L; i++) begin
        checks++;
        if (i >= capq.size() || capq[i] !== expq[i]) begin
          errors++; $display("[TB] FAIL ovr%0d_byte%0d: got %h want %h", n, i, (i < capq.size()) ? capq[i] : 8'h00, expq[i]); end
      end
      finish_idle();
    end
  endtask

  task test_saturate();
    bit ok;
    i_tx_busy = 1'b1;
    start_msg(DW'($urandom()));
    repeat (300) begin pulse_tmr(); model_overrun(); @(negedge clk); end
    checks++; if (o_overrun_cnt !== 8'(m_cnt)) begin
      errors++; $display("[TB] FAIL ovr_saturate: got %0d want %0d", o_overrun_cnt, m_cnt); end
    i_tx_busy = 1'b0;
    wait_bytes(L, 1'b0, ok);
    checks++; if (!ok || capq[2] !== expq[2]) begin
      errors++; $display("[TB] FAIL sat_msg_flag: got %h want %h", capq[2], expq[2]); end
    finish_idle();
  endtask

  task test_rst_mid();
    bit ok;
    int bad = 0;
    start_msg(DW'($urandom()));
    wait_bytes(5, 1'b0, ok);
    rst = 1'b1; i_tmr = 1'b1; i_rx_data = "m"; i_new_rx_data = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_tmr = 1'b0; i_new_rx_data = 1'b0;
    model_reset();
    checks++; if ({o_tx_data, o_new_tx_data, o_motor_armed, o_data_record, o_paused, o_msg_busy} !== 13'h0
               || o_overrun_cnt !== 8'h00) begin
      errors++; $display("[TB] FAIL rst_outputs: got tx=%h new=%b arm=%b rec=%b pau=%b busy=%b cnt=%0d want all 0",
        o_tx_data, o_new_tx_data, o_motor_armed, o_data_record, o_paused, o_msg_busy, o_overrun_cnt); end
    repeat (20) begin
      @(negedge clk);
      if (o_new_tx_data !== 1'b0 || capq.size() != 5) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL rst_silence: got %0d bad cycles want 0", bad); end
    start_msg(DW'($urandom()));
    wait_bytes(L, 1'b0, ok);
    for (int i = 0; i < L; i++) begin
      checks++;
      if (i >= capq.size() || capq[i] !== expq[i]) begin
        errors++; $display("[TB] FAIL rst_next_byte%0d: got %h want %h", i, (i < capq.size()) ? capq[i] : 8'h00, expq[i]); end
    end
    finish_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_commands();
    test_random();
    test_back_to_back_busy();
    test_overrun();
    test_saturate();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
